// File: rtl/dpi_poke_bank.sv
// Multi-channel register bank loaded through per-channel staging tasks.
// Task-side staging is committed to the visible outputs on the clock edge after a request.
module dpi_poke_bank #(
    parameter int WIDTH = 40,
    parameter int NCH   = 4,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [NCH*WIDTH-1:0]  value,
    output logic [NCH-1:0]        valid,
    output logic [NCH-1:0]        busy,
    output logic [NCH*CNTW-1:0]   commit_cnt,
    output logic                  err
);

    localparam int WORDS = (WIDTH + 31) / 32;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Written only by the tasks; deliberately never reset.
    logic [31:0]          staging [NCH][WORDS];
    logic [NCH-1:0]       req_tgl;
    logic                 err_tgl;

    // Written only by the clocked process.
    logic [NCH-1:0]       ack_tgl;
    logic                 err_seen;
    logic [WIDTH-1:0]     value_reg [NCH];
    logic [CNTW-1:0]      cnt_reg   [NCH];
    logic [NCH-1:0]       valid_reg;
    logic                 err_reg;

    logic [WORDS*32-1:0]  staged [NCH];

    task set_word(input int chan, input int idx, input int data);
        if (chan >= 0 && chan < NCH && idx >= 0 && idx < WORDS)
            staging[chan[CHW-1:0]][idx[WIW-1:0]] = data;
        else
            err_tgl = ~err_tgl;
    endtask

    // Pending state is read from the toggles directly so two calls in one time step coalesce.
    task set_commit(input int chan);
        if (chan >= 0 && chan < NCH) begin
            if (req_tgl[chan[CHW-1:0]] ^ ack_tgl[chan[CHW-1:0]])
                err_tgl = ~err_tgl;
            else
                req_tgl[chan[CHW-1:0]] = ~req_tgl[chan[CHW-1:0]];
        end else begin
            err_tgl = ~err_tgl;
        end
    endtask

    assign busy = req_tgl ^ ack_tgl;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            for (genvar gw = 0; gw < WORDS; gw++) begin : g_word
                assign staged[gi][gw*32 +: 32] = staging[gi][gw];
            end
            assign value[gi*WIDTH +: WIDTH]     = value_reg[gi];
            assign commit_cnt[gi*CNTW +: CNTW]  = cnt_reg[gi];
        end
    endgenerate

    // Reset absorbs any outstanding toggles so pending requests and errors are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                value_reg[c] <= '0;
                cnt_reg[c]   <= '0;
            end
            valid_reg <= '0;
            ack_tgl   <= req_tgl;
            err_seen  <= err_tgl;
            err_reg   <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (busy[c]) begin
                    value_reg[c] <= staged[c][WIDTH-1:0];
                    ack_tgl[c]   <= req_tgl[c];
                    cnt_reg[c]   <= cnt_reg[c] + 1'b1;
                end
                valid_reg[c] <= busy[c];
            end
            if (err_tgl != err_seen) begin
                err_reg  <= 1'b1;
                err_seen <= err_tgl;
            end
        end
    end

    assign valid = valid_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_dpi_poke_bank.sv
// Self-checking bench for dpi_poke_bank: directed table, corner sequences and random calls vs a model.
module tb_dpi_poke_bank;

    localparam int WIDTH = 40;
    localparam int NCH   = 4;
    localparam int CNTW  = 8;
    localparam int WORDS = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NCH*WIDTH-1:0] value;
    logic [NCH-1:0]       valid;
    logic [NCH-1:0]       busy;
    logic [NCH*CNTW-1:0]  commit_cnt;
    logic                 err;

    dpi_poke_bank #(.WIDTH(WIDTH), .NCH(NCH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .valid      (valid),
        .busy       (busy),
        .commit_cnt (commit_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: staged words, pending flags, visible state.
    logic [WORDS*32-1:0] m_stage [NCH];
    logic [WIDTH-1:0]    m_value [NCH];
    int                  m_cnt   [NCH];
    bit                  m_pend  [NCH];
    bit                  m_valid [NCH];
    bit                  m_err;
    bit                  m_err_pend;

    typedef struct {
        int              chan;
        logic [31:0]     lo;
        logic [31:0]     hi;
        logic [WIDTH-1:0] exp_value;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH*WIDTH-1:0] ev;
        logic [NCH-1:0]       evld;
        logic [NCH-1:0]       ebusy;
        logic [NCH*CNTW-1:0]  ecnt;
        for (int c = 0; c < NCH; c++) begin
            ev[c*WIDTH +: WIDTH] = m_value[c];
            evld[c]              = m_valid[c];
            ebusy[c]             = m_pend[c];
            ecnt[c*CNTW +: CNTW] = CNTW'(m_cnt[c]);
        end
        check({tag, " value"}, 256'(value), 256'(ev));
        check({tag, " valid"}, 256'(valid), 256'(evld));
        check({tag, " busy"}, 256'(busy), 256'(ebusy));
        check({tag, " commit_cnt"}, 256'(commit_cnt), 256'(ecnt));
        check({tag, " err"}, 256'(err), 256'(m_err));
    endtask

    task automatic word(input int c, input int i, input logic [31:0] d);
        dut.set_word(c, i, int'(d));
        if (c >= 0 && c < NCH && i >= 0 && i < WORDS)
            m_stage[c][i*32 +: 32] = d;
        else
            m_err_pend = 1'b1;
    endtask

    task automatic commit(input int c);
        dut.set_commit(c);
        if (c >= 0 && c < NCH && !m_pend[c])
            m_pend[c] = 1'b1;
        else
            m_err_pend = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        for (int c = 0; c < NCH; c++) begin
            m_valid[c] = m_pend[c];
            if (m_pend[c]) begin
                m_value[c] = m_stage[c][WIDTH-1:0];
                m_cnt[c]   = (m_cnt[c] + 1) % (1 << CNTW);
                m_pend[c]  = 1'b0;
            end
        end
        if (m_err_pend) m_err = 1'b1;
        m_err_pend = 1'b0;
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_value[c] = '0;
            m_cnt[c]   = 0;
            m_valid[c] = 1'b0;
            m_pend[c]  = 1'b0;
        end
        m_err      = 1'b0;
        m_err_pend = 1'b0;
        #1 check_all("in_reset");
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_all("after_reset");
    endtask

    initial begin
        int start_cnt;
        int ncalls;

        for (int c = 0; c < NCH; c++) begin
            m_stage[c] = '0;
            m_value[c] = '0;
            m_cnt[c]   = 0;
            m_pend[c]  = 1'b0;
            m_valid[c] = 1'b0;
        end
        m_err = 1'b0;
        m_err_pend = 1'b0;

        vecs[0] = '{chan: 1, lo: 32'hdeadbeef, hi: 32'hffffff12, exp_value: 40'h12deadbeef};
        vecs[1] = '{chan: 0, lo: 32'h01234567, hi: 32'h89abcdef, exp_value: 40'hef01234567};
        vecs[2] = '{chan: 2, lo: 32'h00000000, hi: 32'hffffff00, exp_value: 40'h0000000000};
        vecs[3] = '{chan: 3, lo: 32'hffffffff, hi: 32'hffffffff, exp_value: 40'hffffffffff};

        #2;
        do_reset(2);

        // Directed single-channel commits, including top-word masking.
        for (int v = 0; v < 4; v++) begin
            word(vecs[v].chan, 0, vecs[v].lo);
            word(vecs[v].chan, 1, vecs[v].hi);
            commit(vecs[v].chan);
            #1 check("busy_on_call", 256'(busy), 256'(4'b0001 << vecs[v].chan));
            step();
            check_all("table");
            check("table value", 256'(value[vecs[v].chan*WIDTH +: WIDTH]), 256'(vecs[v].exp_value));
            check("table valid", 256'(valid), 256'(4'b0001 << vecs[v].chan));
            step();
            check("table valid_fall", 256'(valid), 256'(0));
        end

        // All four channels commit on one edge.
        for (int c = 0; c < NCH; c++) begin
            word(c, 0, 32'h11110000 + 32'(c));
            word(c, 1, 32'h22220000 + 32'(c));
        end
        for (int c = 0; c < NCH; c++) commit(c);
        step();
        check_all("all4");
        check("all4 valid", 256'(valid), 256'(4'b1111));
        step();
        check_all("all4_fall");

        // Overrun: double request coalesces and sets sticky err.
        commit(2);
        commit(2);
        step();
        check_all("overrun");
        check("overrun err", 256'(err), 256'(1));
        step();
        check_all("overrun_sticky");
        do_reset(2);
        check("reset clears err", 256'(err), 256'(0));

        // Invalid calls leave staging alone but flag err.
        word(4, 0, 32'hcafef00d);
        word(0, 2, 32'hcafef00d);
        commit(-1);
        step();
        check_all("invalid");
        commit(0);
        step();
        check_all("invalid_staging_kept");

        // Counter wrap on channel 3.
        start_cnt = m_cnt[3];
        for (int n = 0; n < (1 << CNTW); n++) begin
            word(3, 0, $urandom);
            word(3, 1, $urandom);
            commit(3);
            step();
            check_all("wrap");
        end
        check("wrap cnt3", 256'(commit_cnt[3*CNTW +: CNTW]), 256'(start_cnt));

        // Reset between request and edge discards the commit.
        do_reset(1);
        word(0, 0, 32'h0badc0de);
        word(0, 1, 32'h000000a5);
        commit(0);
        #1 do_reset(2);
        check("reset_drop value0", 256'(value[WIDTH-1:0]), 256'(0));
        check("reset_drop busy", 256'(busy), 256'(0));
        step();
        check_all("reset_drop_edge");
        commit(0);
        step();
        check_all("retained");
        check("retained value0", 256'(value[WIDTH-1:0]), 256'(40'ha50badc0de));

        // Randomized calls, valid and invalid, checked against the model.
        for (int n = 0; n < 300; n++) begin
            ncalls = int'($urandom_range(0, 3));
            for (int k = 0; k < ncalls; k++) begin
                if ($urandom_range(0, 1) == 0)
                    word(int'($urandom_range(0, 5)) - 1, int'($urandom_range(0, 3)) - 1, $urandom);
                else
                    commit(int'($urandom_range(0, 5)) - 1);
            end
            step();
            check_all("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
